// File: rtl/count_display.sv
// count_display: registers a 4-bit count, splits it into two decimal digits,
// time-multiplexes them onto a two-digit common-anode 7-segment display and
// counts wrap-around events (15->0 and 0->15) with a saturating tally.
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   count      counter value 0..15
//   seg        segments, active-low, {g,f,e,d,c,b,a}
//   an         digit enables, active-low, an[0]=units, an[1]=tens
//   wrap_up    one-cycle pulse on a 15->0 transition
//   wrap_down  one-cycle pulse on a 0->15 transition
//   wrap_total wraps in either direction, saturating at 255
// Define COUNT_DISP_BLANK_EN to blank a leading-zero tens digit.
module count_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       wrap_up,
  output logic       wrap_down,
  output logic [7:0] wrap_total
);
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);
  localparam logic [0:0] DIG_UNITS = 1'b0;
  localparam logic [0:0] DIG_TENS  = 1'b1;

  logic [3:0]    count_q, prev_q, units;
  logic          tens, armed, primed, tick, up_hit, down_hit;
  logic [0:0]    state;
  logic [PW-1:0] presc;
  logic [6:0]    tens_seg, units_seg;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    tens      = count_q >= 4'd10;
    units     = tens ? count_q - 4'd10 : count_q;
    tick      = presc == LAST;
    up_hit    = primed && prev_q == 4'd15 && count_q == 4'd0;
    down_hit  = primed && prev_q == 4'd0 && count_q == 4'd15;
    units_seg = decode(units);
`ifdef COUNT_DISP_BLANK_EN
    tens_seg  = tens ? decode(4'd1) : 7'h7F;
`else
    tens_seg  = decode({3'b000, tens});
`endif
  end

  // primed rises on the second edge after release, so the reset value of
  // prev_q is never compared against a real sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      prev_q     <= '0;
      armed      <= 1'b0;
      primed     <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_down  <= 1'b0;
      wrap_total <= '0;
      presc      <= '0;
      state      <= DIG_UNITS;
      seg        <= 7'h7F;
      an         <= 2'b11;
    end else begin
      count_q   <= count;
      prev_q    <= count_q;
      armed     <= 1'b1;
      primed    <= armed;
      wrap_up   <= up_hit;
      wrap_down <= down_hit;
      if ((up_hit || down_hit) && wrap_total != 8'hFF) wrap_total <= wrap_total + 8'd1;
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        state <= ~state;
        an    <= (state == DIG_UNITS) ? 2'b01 : 2'b10;
        seg   <= (state == DIG_UNITS) ? tens_seg : units_seg;
      end
    end
  end
endmodule

// File: tb/tb_count_display.sv
// tb_count_display: directed self-checking bench for count_display with REFRESH_DIV = 4.
module tb_count_display;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count = 4'd12;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap_up, wrap_down;
  logic [7:0] wrap_total;
  int n_chk = 0;
  int n_fail = 0;

  count_display #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .count(count), .seg(seg), .an(an),
    .wrap_up(wrap_up), .wrap_down(wrap_down), .wrap_total(wrap_total)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    step(3);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_an", {6'b0, an}, 8'h03);
    chk("rst_up", {7'b0, wrap_up}, 8'h00);
    chk("rst_down", {7'b0, wrap_down}, 8'h00);
    chk("rst_total", wrap_total, 8'h00);
    rst = 1'b1;
    step(1);
    chk("dark_e1", {6'b0, an}, 8'h03);
    step(2);
    chk("dark_e3", {6'b0, an}, 8'h03);
    chk("dark_e3_seg", {1'b0, seg}, 8'h7F);
    step(1);
    chk("t12_an", {6'b0, an}, 8'h01);
    chk("t12_seg", {1'b0, seg}, 8'h79);
    step(1);
    chk("t12_hold_an", {6'b0, an}, 8'h01);
    chk("t12_hold_seg", {1'b0, seg}, 8'h79);
    step(3);
    chk("u12_an", {6'b0, an}, 8'h02);
    chk("u12_seg", {1'b0, seg}, 8'h24);
    step(4);
    chk("t12b_an", {6'b0, an}, 8'h01);
    chk("t12b_seg", {1'b0, seg}, 8'h79);
    count = 4'd13; step(1);
    count = 4'd14; step(1);
    count = 4'd15; step(1);
    chk("ramp_up_15", {7'b0, wrap_up}, 8'h00);
    count = 4'd0; step(1);
    chk("up_e1", {7'b0, wrap_up}, 8'h00);
    step(1);
    chk("up_e2", {7'b0, wrap_up}, 8'h01);
    chk("up_e2_down", {7'b0, wrap_down}, 8'h00);
    chk("up_total", wrap_total, 8'h01);
    step(1);
    chk("up_e3", {7'b0, wrap_up}, 8'h00);
    count = 4'd15; step(1);
    chk("down_e1", {7'b0, wrap_down}, 8'h00);
    step(1);
    chk("down_e2", {7'b0, wrap_down}, 8'h01);
    chk("down_e2_up", {7'b0, wrap_up}, 8'h00);
    chk("down_total", wrap_total, 8'h02);
    step(1);
    chk("down_e3", {7'b0, wrap_down}, 8'h00);
    count = 4'd3; step(2);
    chk("jump_up", {7'b0, wrap_up}, 8'h00);
    chk("jump_down", {7'b0, wrap_down}, 8'h00);
    chk("jump_total", wrap_total, 8'h02);
    #3 rst = 1'b0;
    #1;
    chk("async_total", wrap_total, 8'h00);
    chk("async_an", {6'b0, an}, 8'h03);
    chk("async_seg", {1'b0, seg}, 8'h7F);
    count = 4'd15;
    step(1);
    rst = 1'b1;
    step(1);
    chk("rel_e1_down", {7'b0, wrap_down}, 8'h00);
    step(1);
    chk("rel_e2_down", {7'b0, wrap_down}, 8'h00);
    step(1);
    chk("rel_e3_down", {7'b0, wrap_down}, 8'h00);
    chk("rel_total", wrap_total, 8'h00);
    rst = 1'b0;
    count = 4'd5;
    step(1);
    rst = 1'b1;
    step(3);
    chk("c5_dark", {6'b0, an}, 8'h03);
    step(1);
    chk("c5_tens_an", {6'b0, an}, 8'h01);
`ifdef COUNT_DISP_BLANK_EN
    chk("c5_tens_seg", {1'b0, seg}, 8'h7F);
`else
    chk("c5_tens_seg", {1'b0, seg}, 8'h40);
`endif
    step(4);
    chk("c5_units_an", {6'b0, an}, 8'h02);
    chk("c5_units_seg", {1'b0, seg}, 8'h12);
    for (int i = 0; i < 300; i++) begin
      count = (i % 2 == 0) ? 4'd15 : 4'd0;
      step(1);
    end
    chk("sat_total", wrap_total, 8'hFF);
    count = 4'd15;
    step(1);
    chk("sat_hold", wrap_total, 8'hFF);
    chk("sat_pulse", {7'b0, wrap_up ^ wrap_down}, 8'h01);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
